// File: rtl/dsep_param_if.sv
// rtl/dsep_param_if.sv - sample, sync-report and output bundle for dsep_param
interface dsep_param_if #(
    parameter int DW = 12,
    parameter int IW = 10,
    parameter int LW = 14
);
    logic [DW-1:0] di_re;
    logic [DW-1:0] di_im;
    logic          di_vld;
    logic [IW-1:0] max_indx;
    logic          max_indx_vld;
    logic [LW-1:0] cfg_pld_len;
    logic [DW-1:0] do_preamble_re;
    logic [DW-1:0] do_preamble_im;
    logic          do_preamble_vld;
    logic [DW-1:0] do_sigpld_re;
    logic [DW-1:0] do_sigpld_im;
    logic          do_sigpld_vld;
    logic          busy;
    logic          done;
    logic          ovf_err;

    modport master (
        output di_re, di_im, di_vld, max_indx, max_indx_vld, cfg_pld_len,
        input  do_preamble_re, do_preamble_im, do_preamble_vld,
        input  do_sigpld_re, do_sigpld_im, do_sigpld_vld, busy, done, ovf_err
    );

    modport slave (
        input  di_re, di_im, di_vld, max_indx, max_indx_vld, cfg_pld_len,
        output do_preamble_re, do_preamble_im, do_preamble_vld,
        output do_sigpld_re, do_sigpld_im, do_sigpld_vld, busy, done, ovf_err
    );
endinterface

// File: rtl/dsep_param.sv
// rtl/dsep_param.sv - data separator: buffers samples, replays preamble and sig+payload (optional DSEP_CP_STRIP_EN)
module dsep_param #(
    parameter int DW          = 12,
    parameter int AW          = 11,
    parameter int IW          = 10,
    parameter int LW          = 14,
    parameter int SYNC_OFFSET = 1566,
    parameter int PRE_LEN     = 320,
    parameter int SYM_LEN     = 80,
    parameter int CP_LEN      = 16
) (
    input logic         clk,
    input logic         rst,
    dsep_param_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PRE  = 2'd1;
    localparam logic [1:0] PLD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [15:0] DEPTH    = 16'(1 << AW);
    localparam logic [15:0] DEPTH_M1 = 16'((1 << AW) - 1);

    logic [2*DW-1:0] mem_q [0:(1<<AW)-1];
    logic [2*DW-1:0] rdata_q;
    logic [2*DW-1:0] out_q;

    logic [1:0]    state_q, state_d;
    logic [15:0]   wr_cnt_q, wr_cnt_d;
    logic [15:0]   rd_cnt_q, rd_cnt_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic          rebase_q, rebase_d;
    logic          s1_vld_q, s1_pld_q;
    logic          pre_vld_q, pld_vld_q;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          rd_en, emit, is_pld;
    logic [15:0]   start, lag;
    logic          future, lap, can_read;
    logic [AW-1:0] wr_addr;
`ifdef DSEP_CP_STRIP_EN
    logic [15:0]   sym_pos_q, sym_pos_d;
`endif

    // Writer bookkeeping; the first sample after a finished frame becomes index 0
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        wr_addr  = rebase_q ? '0 : wr_cnt_q[AW-1:0];
        if (bus.di_vld) begin
            wr_cnt_d = rebase_q ? 16'd1 : wr_cnt_q + 16'd1;
        end
    end

    assign start    = 16'(SYNC_OFFSET) + 16'(bus.max_indx);
    assign future   = start > wr_cnt_d;
    assign lag      = wr_cnt_d - start;
    assign lap      = (rd_cnt_q <= wr_cnt_q) && ((wr_cnt_q - rd_cnt_q) >= DEPTH);
    assign can_read = rd_cnt_q < wr_cnt_q;

    // Frame sequencing: read issue, phase counting, overflow and completion
    always_comb begin
        state_d  = state_q;
        rd_cnt_d = rd_cnt_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        rebase_d = rebase_q & ~bus.di_vld;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
        rd_en    = 1'b0;
        emit     = 1'b1;
        is_pld   = 1'b0;
`ifdef DSEP_CP_STRIP_EN
        sym_pos_d = sym_pos_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.max_indx_vld) begin
                    if (!future && (lag > DEPTH_M1)) begin
                        ovf_d = 1'b1;
                    end else begin
                        rd_cnt_d = start;
                        len_d    = bus.cfg_pld_len;
                        cnt_d    = '0;
                        state_d  = PRE;
                    end
                end
            end
            PRE: begin
                if (lap) begin
                    ovf_d   = 1'b1;
                    state_d = IDLE;
                end else if (can_read) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 16'd1;
                    if (cnt_q == LW'(PRE_LEN - 1)) begin
                        cnt_d   = '0;
                        state_d = (len_q == '0) ? DONE : PLD;
`ifdef DSEP_CP_STRIP_EN
                        sym_pos_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PLD: begin
                is_pld = 1'b1;
                if (lap) begin
                    ovf_d   = 1'b1;
                    state_d = IDLE;
                end else if (can_read) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + 16'd1;
`ifdef DSEP_CP_STRIP_EN
                    // Cyclic prefix samples are consumed but never emitted
                    emit      = sym_pos_q >= 16'(CP_LEN);
                    sym_pos_d = (sym_pos_q == 16'(SYM_LEN - 1)) ? '0 : sym_pos_q + 16'd1;
`endif
                    if (cnt_q == len_q - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // Last read has left the RAM stage once s1 is empty
                if (!s1_vld_q) begin
                    done_d   = 1'b1;
                    rebase_d = 1'b1;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    // Sample buffer: one write port, one registered read port
    always_ff @(posedge clk) begin
        if (bus.di_vld) begin
            mem_q[wr_addr] <= {bus.di_re, bus.di_im};
        end
        if (rd_en) begin
            rdata_q <= mem_q[rd_cnt_q[AW-1:0]];
        end
    end

    // State, counters and the two-stage output pipeline
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            rebase_q  <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_pld_q  <= 1'b0;
            pre_vld_q <= 1'b0;
            pld_vld_q <= 1'b0;
            out_q     <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef DSEP_CP_STRIP_EN
            sym_pos_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            rebase_q  <= rebase_d;
            s1_vld_q  <= rd_en & emit;
            s1_pld_q  <= is_pld;
            pre_vld_q <= s1_vld_q & ~s1_pld_q;
            pld_vld_q <= s1_vld_q & s1_pld_q;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            if (s1_vld_q) begin
                out_q <= rdata_q;
            end
`ifdef DSEP_CP_STRIP_EN
            sym_pos_q <= sym_pos_d;
`endif
        end
    end

    assign bus.do_preamble_re  = out_q[2*DW-1:DW];
    assign bus.do_preamble_im  = out_q[DW-1:0];
    assign bus.do_preamble_vld = pre_vld_q;
    assign bus.do_sigpld_re    = out_q[2*DW-1:DW];
    assign bus.do_sigpld_im    = out_q[DW-1:0];
    assign bus.do_sigpld_vld   = pld_vld_q;
    assign bus.busy            = (state_q == PRE) || (state_q == PLD);
    assign bus.done            = done_q;
    assign bus.ovf_err         = ovf_q;
endmodule
